// File: rtl/data_axi_bridge.sv
// Data-side bridge between the MEM stage's SRAM-like request port and AXI.
// Each request becomes one single-beat AXI read or write, with only one outstanding at a time.
module data_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_D  = 3'd2;
    localparam logic [2:0] S_WR_AW = 3'd3;
    localparam logic [2:0] S_WR_B  = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_data_ok;

    logic              w_accept;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_aw_fin;
    logic              w_w_fin;
    logic [3:0]        w_strb;

    assign w_accept     = data_req && (r_state == S_IDLE);
    assign data_addr_ok = w_accept;
    assign data_data_ok = r_data_ok;
    assign data_rdata   = r_rdata;

    // All valid/ready outputs decode straight from state so an async reset drops them at once.
    assign arvalid = (r_state == S_RD_A);
    assign rready  = (r_state == S_RD_D);
    assign awvalid = (r_state == S_WR_AW) && !r_aw_done;
    assign wvalid  = (r_state == S_WR_AW) && !r_w_done;
    assign bready  = (r_state == S_WR_B);

    assign araddr = r_addr;
    assign awaddr = r_addr;
    assign arsize = {1'b0, r_size};
    assign awsize = {1'b0, r_size};
    assign wdata  = r_wdata;
    assign wstrb  = w_strb;

    assign w_ar_hs  = arvalid && arready;
    assign w_r_hs   = rready && rvalid;
    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_b_hs   = bready && bvalid;
    assign w_aw_fin = r_aw_done || w_aw_hs;
    assign w_w_fin  = r_w_done || w_w_hs;

    // Size 2'b11 is not a legal access, so it goes out with no byte lanes enabled.
    always_comb begin
        w_strb = 4'b0000;
        case (r_size)
            2'b00:   w_strb = 4'b0001 << r_addr[1:0];
            2'b01:   w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_size    <= 2'b00;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_data_ok <= 1'b0;
        end else begin
            r_data_ok <= w_r_hs || w_b_hs;
            if (w_r_hs) begin
                r_rdata <= rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= data_addr;
                        r_size    <= data_size;
                        r_wdata   <= data_wdata;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= data_wr ? S_WR_AW : S_RD_A;
                    end
                end
                S_RD_A: begin
                    if (w_ar_hs) begin
                        r_state <= S_RD_D;
                    end
                end
                S_RD_D: begin
                    if (w_r_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WR_AW: begin
                    // AW and W complete independently; leave only once both have handshaken.
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (w_b_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: it plays the MEM master and the AXI slave,
// and compares the bridge against expectations derived from the request parameters.
module tb_data_axi_bridge;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int          nChecks;
    int          nPass;
    logic [31:0] lastRdata;

    data_axi_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte lanes touched by an access: a naturally aligned group of 2**size bytes.
    function automatic logic [31:0] expStrb(input logic [1:0] size, input logic [31:0] addr);
        int nBytes;
        int offset;
        if (size == 2'd3) return 32'd0;
        nBytes = 1 << size;
        offset = ((addr % 4) / nBytes) * nBytes;
        return 32'(((1 << nBytes) - 1) << offset) & 32'hF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction as MEM master plus AXI slave; returns in the data_ok cycle.
    // Reads: d0 = AR wait, d1 = R wait. Writes: d0 = AW wait, d1 = W wait, d2 = B wait.
    task automatic applyStimulus(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int d0, input int d1, input int d2);
        bit hs;
        bit awSeen;
        bit wSeen;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wd;
        #1;
        checkOutput("addr_ok", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req   = 1'b0;
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
        if (!wr) begin
            hs = 1'b0;
            for (int c = 0; c < 40 && !hs; c++) begin
                arready = (c >= d0);
                #1;
                checkOutput("arvalid", 32'(arvalid), 32'd1);
                checkOutput("araddr", araddr, addr);
                checkOutput("arsize", 32'(arsize), 32'(size));
                checkOutput("data_ok_quiet", 32'(data_data_ok), 32'd0);
                hs = arvalid && arready;
                @(negedge clk);
            end
            checkOutput("ar_handshake", 32'(hs), 32'd1);
            arready = 1'b0;
            hs = 1'b0;
            for (int c = 0; c < 40 && !hs; c++) begin
                rvalid = (c >= d1);
                rdata  = rvalid ? rd : $urandom;
                #1;
                checkOutput("arvalid_drop", 32'(arvalid), 32'd0);
                checkOutput("rready", 32'(rready), 32'd1);
                checkOutput("data_ok_quiet", 32'(data_data_ok), 32'd0);
                hs = rvalid && rready;
                @(negedge clk);
            end
            checkOutput("r_handshake", 32'(hs), 32'd1);
            rvalid = 1'b0;
            rdata  = $urandom;
            #1;
            lastRdata = rd;
            checkOutput("rd_data_ok", 32'(data_data_ok), 32'd1);
            checkOutput("data_rdata", data_rdata, lastRdata);
        end else begin
            awSeen = 1'b0;
            wSeen  = 1'b0;
            for (int c = 0; c < 40 && !(awSeen && wSeen); c++) begin
                awready = !awSeen && (c >= d0);
                wready  = !wSeen && (c >= d1);
                #1;
                checkOutput("awvalid", 32'(awvalid), 32'(!awSeen));
                checkOutput("wvalid", 32'(wvalid), 32'(!wSeen));
                if (!awSeen) begin
                    checkOutput("awaddr", awaddr, addr);
                    checkOutput("awsize", 32'(awsize), 32'(size));
                end
                if (!wSeen) begin
                    checkOutput("wdata", wdata, wd);
                    checkOutput("wstrb", 32'(wstrb), expStrb(size, addr));
                end
                checkOutput("bready_early", 32'(bready), 32'd0);
                checkOutput("data_ok_quiet", 32'(data_data_ok), 32'd0);
                if (awvalid && awready) awSeen = 1'b1;
                if (wvalid && wready) wSeen = 1'b1;
                @(negedge clk);
            end
            checkOutput("aw_w_handshake", 32'(awSeen && wSeen), 32'd1);
            awready = 1'b0;
            wready  = 1'b0;
            hs = 1'b0;
            for (int c = 0; c < 40 && !hs; c++) begin
                bvalid = (c >= d2);
                #1;
                checkOutput("bready", 32'(bready), 32'd1);
                checkOutput("aw_w_drop", 32'({awvalid, wvalid}), 32'd0);
                checkOutput("data_ok_quiet", 32'(data_data_ok), 32'd0);
                hs = bvalid && bready;
                @(negedge clk);
            end
            checkOutput("b_handshake", 32'(hs), 32'd1);
            bvalid = 1'b0;
            #1;
            checkOutput("wr_data_ok", 32'(data_data_ok), 32'd1);
            checkOutput("rdata_hold", data_rdata, lastRdata);
        end
    endtask

    // The cycle after a completion must be quiet: the pulse is exactly one cycle wide.
    task automatic idleCycle();
        @(negedge clk);
        #1;
        checkOutput("data_ok_single", 32'(data_data_ok), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        nChecks    = 0;
        nPass      = 0;
        lastRdata  = 32'd0;
        rst        = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'b00;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        arready    = 1'b0;
        rdata      = 32'd0;
        rvalid     = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bready_dummy_guard();

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        checkOutput("reset_data_ok", 32'(data_data_ok), 32'd0);
        checkOutput("reset_rdata", data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        applyStimulus(1'b0, 2'b10, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 2, 0, 0);
        idleCycle();

        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 32'h0000_1003, 32'h5555_5555, 32'd0, 0, 0, 1);
        idleCycle();

        @(negedge clk);
        applyStimulus(1'b1, 2'b01, 32'h0000_2002, 32'h1234_1234, 32'd0, 0, 3, 0);
        idleCycle();
        @(negedge clk);
        applyStimulus(1'b1, 2'b01, 32'h0000_2002, 32'hABCD_ABCD, 32'd0, 3, 0, 2);
        idleCycle();

        // Store then a load presented in the store's data_ok cycle.
        @(negedge clk);
        applyStimulus(1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D, 32'd0, 1, 1, 0);
        applyStimulus(1'b0, 2'b10, 32'h0000_4000, 32'd0, 32'h0BAD_CAFE, 0, 1, 0);
        idleCycle();

        @(negedge clk);
        applyStimulus(1'b1, 2'b11, 32'h0000_5001, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
        idleCycle();

        // Reset while the read data phase is pending.
        @(negedge clk);
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'b10;
        data_addr = 32'h0000_3000;
        #1;
        checkOutput("rst_addr_ok", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0;
        arready  = 1'b1;
        #1;
        checkOutput("rst_arvalid", 32'(arvalid), 32'd1);
        @(negedge clk);
        arready = 1'b0;
        #1;
        checkOutput("rst_in_rd_d", 32'(rready), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        lastRdata = 32'd0;
        checkOutput("rst_valids_drop", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        checkOutput("rst_data_ok", 32'(data_data_ok), 32'd0);
        checkOutput("rst_rdata", data_rdata, lastRdata);
        @(negedge clk);
        rst    = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        #1;
        checkOutput("post_rst_rready", 32'(rready), 32'd0);
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        checkOutput("post_rst_no_pulse", 32'(data_data_ok), 32'd0);
        checkOutput("post_rst_rdata", data_rdata, lastRdata);

        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                idleCycle();
                @(negedge clk);
            end
        end
        idleCycle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    task automatic bready_dummy_guard();
    endtask

endmodule
